sram_burst_ctrl: RTL and testbench
==================================

SRAM_BURST_CTRL -- requirements
Module: sram_burst_ctrl

Interface
REQ-001 SHALL have parameter DW, default 8, memory data width.
REQ-002 SHALL have parameter RAW, default 8, memory row address width.
REQ-003 SHALL have parameter CAW, default 2, memory column address width; full address width AW=RAW+CAW (default 10).
REQ-004 CLK  in  1  single clock; all state changes on posedge.
REQ-005 NRST  in  1  reset, asynchronous, active-low.
REQ-006 HREQ  in  1  host command valid.
REQ-007 HRDY  out  1  command ready; command accepted on edge with HREQ&HRDY.
REQ-008 HWR  in  1  command direction, 1=write burst, 0=read burst.
REQ-009 HADDR  in  AW  burst start address.
REQ-010 HLEN  in  4  burst length minus one (1..16 beats).
REQ-011 WVALID  in  1  host write beat valid.
REQ-012 WREADY  out  1  write beat ready; beat accepted on edge with WVALID&WREADY.
REQ-013 WDATA  in  DW  write beat data.
REQ-014 RVALID  out  1  read beat valid, one-cycle pulse per beat, no backpressure.
REQ-015 RDATA  out  DW  read beat data, valid while RVALID=1.
REQ-016 RLAST  out  1  asserted with RVALID on final beat of a read burst.
REQ-017 NCE  out  1  SRAM chip enable, active-low, registered.
REQ-018 NWRT  out  1  SRAM write enable, active-low (0=write, 1=read), registered.
REQ-019 RA  out  RAW  SRAM row address = current address[AW-1:CAW], registered.
REQ-020 CA  out  CAW  SRAM column address = current address[CAW-1:0], registered.
REQ-021 DIN  out  DW  SRAM write data, registered.
REQ-022 DO  in  DW  SRAM read data, valid before the second posedge after the sampling edge of a read.

Function
REQ-023 SHALL implement states IDLE, WR, RD, DRAIN; HRDY=1 only in IDLE; WREADY=1 only in WR.
REQ-024 IDLE: on accept edge, latch current address=HADDR, beat count=HLEN+1; HWR=1 -> WR; HWR=0 -> RD and issue first read on that same edge.
REQ-025 Read issue (edge): NCE<=0, NWRT<=1, RA/CA<=current address, current address++, count--.
REQ-026 RD: issues one read per cycle on consecutive edges; edge issuing final beat -> DRAIN.
REQ-027 Read return: beat issued at edge E is sampled by SRAM at E+1; DO captured into RDATA at E+2; RVALID=1 in the cycle following E+2; first RVALID two cycles after accept edge.
REQ-028 DRAIN: NCE<=1; transitions to IDLE on the edge that asserts RVALID/RLAST for the final beat.
REQ-029 WR: each accepted beat drives NCE<=0, NWRT<=0, DIN<=WDATA, RA/CA<=current address, address++, count--; edge without WVALID drives NCE<=1.
REQ-030 WR: edge accepting the final beat -> IDLE; the next command's first access is issued no earlier than the edge after that, preserving write-before-read order.
REQ-031 Address increment SHALL wrap modulo 2^AW (1023 -> 0 at default widths); a burst crossing the top continues at 0.
REQ-032 When no access is issued on an edge, NCE<=1, NWRT<=1; RA, CA, DIN hold prior values.
REQ-033 NCE and NWRT SHALL never both be 0 except on an accepted write beat.
REQ-034 HREQ, HADDR, HLEN, HWR SHALL be ignored outside IDLE; WVALID ignored outside WR.
REQ-035 RVALID, RLAST SHALL be registered; RDATA holds last captured value when RVALID=0.

Reset
REQ-036 NRST=0 SHALL immediately force state=IDLE, NCE=1, NWRT=1, RA=0, CA=0, DIN=0, RVALID=0, RLAST=0, RDATA=0, count=0, read-return pipeline cleared.
REQ-037 HRDY=1 and WREADY=0 while NRST=0 and after release.
REQ-038 Reset mid-burst SHALL abort the burst; no further SRAM access and no pending RVALID after reset.
REQ-039 Reset release is synchronous-safe: first command accepted on first posedge with NRST=1 and HREQ=1.

Verification
REQ-040 Write HADDR=0x004, HLEN=3, WDATA 0xA0..0xA3 back-to-back -> 4 cycles NCE=0/NWRT=0, {RA,CA}=0x004..0x007, DIN 0xA0..0xA3.
REQ-041 Read HADDR=0x004, HLEN=3 after REQ-040 -> RVALID 4 consecutive cycles starting 2 cycles after accept, RDATA 0xA0..0xA3, RLAST on 4th.
REQ-042 Write HADDR=0x3FE, HLEN=3 -> addresses 0x3FE, 0x3FF, 0x000, 0x001; readback matches.
REQ-043 Write burst with WVALID low 2 cycles mid-burst -> NCE=1 during gaps, no extra/missing writes, count correct.
REQ-044 Read HLEN=15, NRST=0 after 5th RVALID -> NCE=1, RVALID=0 immediately, HRDY=1; no RVALID after release.
REQ-045 Write single beat to 0x010, read 0x010 accepted the first cycle HRDY=1 -> RDATA equals written value.

Source files
------------

// File: rtl/sram_burst_ctrl.sv
// Burst controller between a host command/beat interface and a single-port synchronous SRAM.
// Reads are pipelined one issue per cycle, with data returned two cycles after issue.
module sram_burst_ctrl #(
    parameter int DW  = 8,
    parameter int RAW = 8,
    parameter int CAW = 2
) (
    input  logic               CLK,
    input  logic               NRST,
    input  logic               HREQ,
    output logic               HRDY,
    input  logic               HWR,
    input  logic [RAW+CAW-1:0] HADDR,
    input  logic [3:0]         HLEN,
    input  logic               WVALID,
    output logic               WREADY,
    input  logic [DW-1:0]      WDATA,
    output logic               RVALID,
    output logic [DW-1:0]      RDATA,
    output logic               RLAST,
    output logic               NCE,
    output logic               NWRT,
    output logic [RAW-1:0]     RA,
    output logic [CAW-1:0]     CA,
    output logic [DW-1:0]      DIN,
    input  logic [DW-1:0]      DO
);
    localparam int AW = RAW + CAW;
    localparam logic [AW-1:0] ADDR_ONE = AW'(1);

    // state | meaning
    // IDLE  | waiting for a host command
    // WR    | accepting write beats, one SRAM write per beat
    // RD    | issuing one SRAM read per cycle
    // DRAIN | all reads issued, waiting for the final beat to return
    typedef enum logic [1:0] {IDLE, WR, RD, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [4:0]      cnt_q, cnt_d;
    logic            nce_q, nce_d;
    logic            nwrt_q, nwrt_d;
    logic [RAW-1:0]  ra_q, ra_d;
    logic [CAW-1:0]  ca_q, ca_d;
    logic [DW-1:0]   din_q, din_d;
    logic            rd_p1_q, rd_p1_d;
    logic            rd_last_p1_q, rd_last_p1_d;
    logic            rd_p2_q, rd_p2_d;
    logic            rd_last_p2_q, rd_last_p2_d;
    logic            rvalid_q, rvalid_d;
    logic            rlast_q, rlast_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic [AW-1:0]   acc_addr;
    logic            issue;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        nce_d        = 1'b1;
        nwrt_d       = 1'b1;
        ra_d         = ra_q;
        ca_d         = ca_q;
        din_d        = din_q;
        acc_addr     = addr_q;
        issue        = 1'b0;
        rd_p1_d      = 1'b0;
        rd_last_p1_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (HREQ) begin
                    acc_addr = HADDR;
                    if (HWR) begin
                        addr_d  = HADDR;
                        cnt_d   = {1'b0, HLEN} + 5'd1;
                        state_d = WR;
                    end else begin
                        // first read goes out on the accept edge itself
                        issue        = 1'b1;
                        rd_p1_d      = 1'b1;
                        rd_last_p1_d = (HLEN == 4'd0);
                        cnt_d        = {1'b0, HLEN};
                        state_d      = (HLEN == 4'd0) ? DRAIN : RD;
                    end
                end
            end
            RD: begin
                issue        = 1'b1;
                rd_p1_d      = 1'b1;
                rd_last_p1_d = (cnt_q == 5'd1);
                cnt_d        = cnt_q - 5'd1;
                if (cnt_q == 5'd1) state_d = DRAIN;
            end
            WR: begin
                if (WVALID) begin
                    issue  = 1'b1;
                    nwrt_d = 1'b0;
                    din_d  = WDATA;
                    cnt_d  = cnt_q - 5'd1;
                    if (cnt_q == 5'd1) state_d = IDLE;
                end
            end
            DRAIN: begin
                if (rd_p2_q && rd_last_p2_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (issue) begin
            nce_d  = 1'b0;
            ra_d   = acc_addr[AW-1:CAW];
            ca_d   = acc_addr[CAW-1:0];
            addr_d = acc_addr + ADDR_ONE;
        end

        rd_p2_d      = rd_p1_q;
        rd_last_p2_d = rd_last_p1_q;
        rvalid_d     = rd_p2_q;
        rlast_d      = rd_p2_q & rd_last_p2_q;
        rdata_d      = rd_p2_q ? DO : rdata_q;
    end

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            cnt_q        <= '0;
            nce_q        <= 1'b1;
            nwrt_q       <= 1'b1;
            ra_q         <= '0;
            ca_q         <= '0;
            din_q        <= '0;
            rd_p1_q      <= 1'b0;
            rd_last_p1_q <= 1'b0;
            rd_p2_q      <= 1'b0;
            rd_last_p2_q <= 1'b0;
            rvalid_q     <= 1'b0;
            rlast_q      <= 1'b0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            nce_q        <= nce_d;
            nwrt_q       <= nwrt_d;
            ra_q         <= ra_d;
            ca_q         <= ca_d;
            din_q        <= din_d;
            rd_p1_q      <= rd_p1_d;
            rd_last_p1_q <= rd_last_p1_d;
            rd_p2_q      <= rd_p2_d;
            rd_last_p2_q <= rd_last_p2_d;
            rvalid_q     <= rvalid_d;
            rlast_q      <= rlast_d;
            rdata_q      <= rdata_d;
        end
    end

    assign HRDY   = (state_q == IDLE);
    assign WREADY = (state_q == WR);
    assign NCE    = nce_q;
    assign NWRT   = nwrt_q;
    assign RA     = ra_q;
    assign CA     = ca_q;
    assign DIN    = din_q;
    assign RVALID = rvalid_q;
    assign RLAST  = rlast_q;
    assign RDATA  = rdata_q;

endmodule

// File: tb/tb_sram_burst_ctrl.sv
// Bench for sram_burst_ctrl: directed vector table, reset corner sequences, then random bursts
// checked against a flat memory model and the documented read latency.
module tb_sram_burst_ctrl;
    localparam int DW = 8, RAW = 8, CAW = 2, AW = 10, MSZ = 1024;

    logic          CLK = 1'b0, NRST = 1'b0, HREQ = 1'b0, HWR = 1'b0, WVALID = 1'b0;
    logic [AW-1:0] HADDR = '0;
    logic [3:0]    HLEN = '0;
    logic [DW-1:0] WDATA = '0;
    logic [DW-1:0] DO = '0;
    logic          HRDY, WREADY, RVALID, RLAST, NCE, NWRT;
    logic [DW-1:0] RDATA, DIN;
    logic [RAW-1:0] RA;
    logic [CAW-1:0] CA;

    always #5 CLK = ~CLK;

    sram_burst_ctrl #(.DW(DW), .RAW(RAW), .CAW(CAW)) dut (
        .CLK(CLK), .NRST(NRST), .HREQ(HREQ), .HRDY(HRDY), .HWR(HWR), .HADDR(HADDR),
        .HLEN(HLEN), .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .RVALID(RVALID),
        .RDATA(RDATA), .RLAST(RLAST), .NCE(NCE), .NWRT(NWRT), .RA(RA), .CA(CA),
        .DIN(DIN), .DO(DO)
    );

    // synchronous SRAM: samples the registered controls on the edge after issue
    logic [DW-1:0] sram [MSZ];
    logic [DW-1:0] ref_mem [MSZ];
    always @(posedge CLK) begin
        if (!NCE) begin
            if (!NWRT) sram[{RA, CA}] <= DIN;
            else       DO <= sram[{RA, CA}];
        end
    end

    typedef struct packed { logic wr; logic [AW-1:0] addr; logic [DW-1:0] data; } acc_t;
    typedef struct packed { logic [DW-1:0] data; logic last; logic hrdy; logic [63:0] t; } beat_t;
    acc_t  acc_q[$];
    beat_t rd_q[$];

    always @(negedge CLK) begin
        if (!NCE) acc_q.push_back({~NWRT, RA, CA, DIN});
        if (RVALID) rd_q.push_back({RDATA, RLAST, HRDY, 64'($time)});
    end

    int n_chk = 0, n_fail = 0;
    logic [DW-1:0] wbuf [16];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge CLK);
        #1;
    endtask

    task automatic wait_rdy();
        int n;
        n = 0;
        while (!HRDY && n < 50) begin
            step();
            n++;
        end
        chk("hrdy_wait", int'(HRDY), 1);
    endtask

    // gap: 0 none, 1 random idle slots, 2 two idle cycles before beat 2
    task automatic do_write(input int addr, input int len, input int gap,
                            output int end_a, output int last_d);
        int i, guard, gcnt;
        bit idle;
        acc_q.delete();
        HREQ = 1'b1; HWR = 1'b1; HADDR = AW'(addr); HLEN = 4'(len - 1);
        wait_rdy();
        @(posedge CLK);
        step();
        HREQ = 1'b0;
        i = 0; guard = 0; gcnt = 0;
        while (i < len && guard < 100) begin
            guard++;
            idle = (gap == 2 && i == 2 && gcnt < 2) || (gap == 1 && $urandom_range(0, 2) == 0);
            if (idle) begin
                WVALID = 1'b0;
                gcnt++;
            end else begin
                WVALID = 1'b1;
                WDATA  = wbuf[i];
                chk("wready", int'(WREADY), 1);
            end
            step();
            if (idle) chk("gap_nce", int'(NCE), 1);
            else begin
                ref_mem[(addr + i) % MSZ] = wbuf[i];
                i++;
            end
        end
        WVALID = 1'b0;
        chk("wr_beats", acc_q.size(), len);
        for (int k = 0; k < acc_q.size() && k < len; k++) begin
            chk("wr_kind", int'(acc_q[k].wr), 1);
            chk("wr_addr", int'(acc_q[k].addr), (addr + k) % MSZ);
            chk("wr_data", int'(acc_q[k].data), int'(wbuf[k]));
        end
        end_a  = (acc_q.size() > 0) ? int'(acc_q[acc_q.size()-1].addr) : -1;
        last_d = (acc_q.size() > 0) ? int'(acc_q[acc_q.size()-1].data) : -1;
        chk("hrdy_after_wr", int'(HRDY), 1);
    endtask

    task automatic do_read(input int addr, input int len, output int end_a, output int last_d);
        logic [63:0] t0;
        int n;
        acc_q.delete();
        rd_q.delete();
        HREQ = 1'b1; HWR = 1'b0; HADDR = AW'(addr); HLEN = 4'(len - 1);
        wait_rdy();
        @(posedge CLK);
        t0 = 64'($time);
        step();
        HREQ = 1'b0;
        n = 0;
        while (rd_q.size() < len && n < len + 10) begin
            step();
            n++;
        end
        repeat (3) step();
        chk("rd_beats", rd_q.size(), len);
        chk("rd_issues", acc_q.size(), len);
        for (int k = 0; k < rd_q.size() && k < len; k++) begin
            chk("rd_data", int'(rd_q[k].data), int'(ref_mem[(addr + k) % MSZ]));
            chk("rd_last", int'(rd_q[k].last), (k == len - 1) ? 1 : 0);
            chk("rd_hrdy", int'(rd_q[k].hrdy), (k == len - 1) ? 1 : 0);
            chk("rd_time", int'(rd_q[k].t - t0), 25 + 10 * k);
        end
        for (int k = 0; k < acc_q.size() && k < len; k++) begin
            chk("rd_kind", int'(acc_q[k].wr), 0);
            chk("rd_addr", int'(acc_q[k].addr), (addr + k) % MSZ);
        end
        end_a  = (acc_q.size() > 0) ? int'(acc_q[acc_q.size()-1].addr) : -1;
        last_d = (rd_q.size() > 0) ? int'(rd_q[rd_q.size()-1].data) : -1;
    endtask

    typedef struct {
        bit         wr;
        int         addr;
        int         len;
        int         gap;
        logic [7:0] d0;
        int         exp_end;
        int         exp_last;
    } vec_t;
    vec_t vecs[8];

    initial begin
        #300000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int ea, ld, n, last_wa;
        vecs[0] = '{1, 'h004, 4, 0, 8'hA0, 'h007, 'hA3};
        vecs[1] = '{0, 'h004, 4, 0, 8'h00, 'h007, 'hA3};
        vecs[2] = '{1, 'h3FE, 4, 0, 8'hB0, 'h001, 'hB3};
        vecs[3] = '{0, 'h3FE, 4, 0, 8'h00, 'h001, 'hB3};
        vecs[4] = '{1, 'h020, 6, 2, 8'hC0, 'h025, 'hC5};
        vecs[5] = '{0, 'h020, 6, 0, 8'h00, 'h025, 'hC5};
        vecs[6] = '{1, 'h010, 1, 0, 8'h5A, 'h010, 'h5A};
        vecs[7] = '{0, 'h010, 1, 0, 8'h00, 'h010, 'h5A};
        for (int i = 0; i < MSZ; i++) begin
            sram[i]    = '0;
            ref_mem[i] = '0;
        end

        repeat (2) @(posedge CLK);
        step();
        chk("rst_nce", int'(NCE), 1);
        chk("rst_nwrt", int'(NWRT), 1);
        chk("rst_ra", int'(RA), 0);
        chk("rst_ca", int'(CA), 0);
        chk("rst_din", int'(DIN), 0);
        chk("rst_rvalid", int'(RVALID), 0);
        chk("rst_rlast", int'(RLAST), 0);
        chk("rst_rdata", int'(RDATA), 0);
        chk("rst_hrdy", int'(HRDY), 1);
        chk("rst_wready", int'(WREADY), 0);
        NRST = 1'b1;
        step();

        for (int v = 0; v < 8; v++) begin
            if (vecs[v].wr) begin
                for (int b = 0; b < vecs[v].len; b++) wbuf[b] = vecs[v].d0 + 8'(b);
                do_write(vecs[v].addr, vecs[v].len, vecs[v].gap, ea, ld);
            end else begin
                do_read(vecs[v].addr, vecs[v].len, ea, ld);
            end
            chk("vec_end_addr", ea, vecs[v].exp_end);
            chk("vec_last_data", ld, vecs[v].exp_last);
        end

        // reset in the middle of a 16-beat read
        acc_q.delete();
        rd_q.delete();
        HREQ = 1'b1; HWR = 1'b0; HADDR = 10'h100; HLEN = 4'hF;
        wait_rdy();
        @(posedge CLK);
        step();
        HREQ = 1'b0;
        n = 0;
        while (rd_q.size() < 5 && n < 20) begin
            step();
            n++;
        end
        chk("abort_5beats", rd_q.size(), 5);
        NRST = 1'b0;
        #1;
        chk("abort_nce", int'(NCE), 1);
        chk("abort_rvalid", int'(RVALID), 0);
        chk("abort_rlast", int'(RLAST), 0);
        chk("abort_hrdy", int'(HRDY), 1);
        chk("abort_wready", int'(WREADY), 0);
        acc_q.delete();
        repeat (2) step();
        NRST = 1'b1;
        repeat (6) step();
        chk("abort_no_rvalid", rd_q.size(), 5);
        chk("abort_no_access", acc_q.size(), 0);

        // command waiting at reset release is taken on the first edge
        NRST = 1'b0;
        step();
        NRST = 1'b1;
        do_read('h004, 4, ea, ld);
        chk("post_rst_last", ld, 'hA3);

        last_wa = 0;
        for (int r = 0; r < 40; r++) begin
            int len, addr;
            len = $urandom_range(1, 16);
            if ($urandom_range(0, 1) == 1) begin
                addr = $urandom_range(0, MSZ - 1);
                for (int b = 0; b < len; b++) wbuf[b] = 8'($urandom);
                do_write(addr, len, int'($urandom_range(0, 1)), ea, ld);
                last_wa = addr;
            end else begin
                addr = ($urandom_range(0, 1) == 1) ? last_wa : int'($urandom_range(0, MSZ - 1));
                do_read(addr, len, ea, ld);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
